// File: rtl/four_bit_serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: default operand width,
// FSM state encoding and a sizing helper for the bit counter.
package four_bit_serial_subtractor_pkg;

  // Default operand/result width; legal range is 2..16.
  localparam int DEF_WIDTH = 4;

  // Controller states: waiting for a request, or shifting bits through.
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Bits needed for a counter that can hold the values 0..w.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 32'd1);
  endfunction

endpackage : four_bit_serial_subtractor_pkg

// File: rtl/four_bit_serial_subtractor_if.sv
// Request/result bundle between a requester (master) and the subtractor (slave).
interface four_bit_serial_subtractor_if
  import four_bit_serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) ();

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             start;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             busy;
  logic             done;

  modport master (
    output a, b, bin, start,
    input  diff, bout, busy, done
  );

  modport slave (
    input  a, b, bin, start,
    output diff, bout, busy, done
  );

endinterface : four_bit_serial_subtractor_if

// File: rtl/four_bit_serial_subtractor_full_subtractor.sv
// One-bit full subtractor: computes a - b - bin for a single bit position.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic borrow
);

  assign diff   = a ^ b ^ bin;
  // Borrow when b exceeds a, or when they are equal and a borrow is pending.
  assign borrow = (~a & b) | (~(a ^ b) & bin);

endmodule : full_subtractor

// File: rtl/four_bit_serial_subtractor.sv
// Bit-serial subtractor: computes (a - b - bin) one bit per clock, LSB first,
// using a single full_subtractor cell and a borrow flop. A request accepted
// at edge E completes at edge E+WIDTH with a one-cycle done pulse.
module four_bit_serial_subtractor
  import four_bit_serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  four_bit_serial_subtractor_if.slave  bus
);

  localparam int               CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic             br_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;
  logic             busy_q;
  logic             done_q;

  // Next values produced by the per-bit cell for the current LSBs.
  logic             bit_d;
  logic             br_d;

  full_subtractor u_fs (
    .a      (a_q[0]),
    .b      (b_q[0]),
    .bin    (br_q),
    .diff   (bit_d),
    .borrow (br_d)
  );

  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

  // Controller FSM plus datapath registers; all outputs are registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // done is a single-cycle pulse unless the final bit sets it below.
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            br_q    <= bus.bin;
            res_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_SHIFT;
          end else begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          // Operands are captured, so start and input changes are ignored here.
          a_q   <= {1'b0, a_q[WIDTH-1:1]};
          b_q   <= {1'b0, b_q[WIDTH-1:1]};
          br_q  <= br_d;
          res_q <= {bit_d, res_q[WIDTH-1:1]};
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BIT) begin
            // The last bit lands directly in diff alongside the final borrow.
            diff_q  <= {bit_d, res_q[WIDTH-1:1]};
            bout_q  <= br_d;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            busy_q  <= 1'b1;
            state_q <= ST_SHIFT;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule : four_bit_serial_subtractor

// File: tb/tb_four_bit_serial_subtractor.sv
// Directed bench for the bit-serial subtractor with hand-computed results.
module tb_four_bit_serial_subtractor;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   done_cnt;

  four_bit_serial_subtractor_if #(.WIDTH(4)) bus_if ();

  four_bit_serial_subtractor #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Advance past the next rising edge; inputs are driven and outputs sampled here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request and clock it in at edge E, then scramble the inputs.
  task automatic start_op(input logic [3:0] a_v, input logic [3:0] b_v, input logic bin_v);
    bus_if.a     = a_v;
    bus_if.b     = b_v;
    bus_if.bin   = bin_v;
    bus_if.start = 1'b1;
    step();
    bus_if.start = 1'b0;
    bus_if.a     = 4'($urandom_range(0, 15));
    bus_if.b     = 4'($urandom_range(0, 15));
    bus_if.bin   = 1'($urandom_range(0, 1));
  endtask

  // Walk edges E+1..E+4, checking busy/done timing and the final result.
  task automatic finish_check(input string tag, input logic [3:0] exp_d, input logic exp_b);
    check_eq({tag, "_busy_E"}, 32'(bus_if.busy), 32'd1);
    for (int k = 1; k <= 4; k++) begin
      step();
      if (k < 4) begin
        check_eq({tag, "_busy_mid"}, 32'(bus_if.busy), 32'd1);
        check_eq({tag, "_done_mid"}, 32'(bus_if.done), 32'd0);
      end else begin
        check_eq({tag, "_done"}, 32'(bus_if.done), 32'd1);
        check_eq({tag, "_busy_end"}, 32'(bus_if.busy), 32'd0);
        check_eq({tag, "_diff"}, 32'(bus_if.diff), 32'(exp_d));
        check_eq({tag, "_bout"}, 32'(bus_if.bout), 32'(exp_b));
      end
    end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rst_n        = 1'b0;
    bus_if.a     = 4'd0;
    bus_if.b     = 4'd0;
    bus_if.bin   = 1'b0;
    bus_if.start = 1'b0;
    step();
    step();
    check_eq("rst_diff", 32'(bus_if.diff), 32'd0);
    check_eq("rst_bout", 32'(bus_if.bout), 32'd0);
    check_eq("rst_busy", 32'(bus_if.busy), 32'd0);
    check_eq("rst_done", 32'(bus_if.done), 32'd0);

    // start coincident with reset must be ignored
    bus_if.a     = 4'd9;
    bus_if.b     = 4'd3;
    bus_if.start = 1'b1;
    step();
    check_eq("rst_start_busy", 32'(bus_if.busy), 32'd0);
    bus_if.start = 1'b0;
    rst_n        = 1'b1;
    step();
    check_eq("rst_start_idle", 32'(bus_if.busy), 32'd0);

    // 9 - 3 = 6, then result holds
    start_op(4'd9, 4'd3, 1'b0);
    finish_check("9m3", 4'd6, 1'b0);
    step();
    check_eq("9m3_done_drop", 32'(bus_if.done), 32'd0);
    check_eq("9m3_hold", 32'(bus_if.diff), 32'd6);

    // 3 - 9 wraps to 10 with borrow
    start_op(4'd3, 4'd9, 1'b0);
    finish_check("3m9", 4'd10, 1'b1);
    step();

    // 0 - 0 - 1 gives all ones, then equal operands give zero
    start_op(4'd0, 4'd0, 1'b1);
    finish_check("0m0b", 4'd15, 1'b1);
    step();
    start_op(4'd5, 4'd5, 1'b0);
    finish_check("5m5", 4'd0, 1'b0);
    step();

    // start while busy is ignored: 12 - 1 = 11, single done
    start_op(4'd12, 4'd1, 1'b0);
    done_cnt = 0;
    step();
    bus_if.a     = 4'd0;
    bus_if.b     = 4'd15;
    bus_if.start = 1'b1;
    step();
    bus_if.start = 1'b0;
    if (bus_if.done) done_cnt++;
    step();
    if (bus_if.done) done_cnt++;
    step();
    if (bus_if.done) done_cnt++;
    check_eq("busy_ign_diff", 32'(bus_if.diff), 32'd11);
    check_eq("busy_ign_bout", 32'(bus_if.bout), 32'd0);
    for (int k = 0; k < 8; k++) begin
      step();
      if (bus_if.done) done_cnt++;
    end
    check_eq("busy_ign_dones", 32'(done_cnt), 32'd1);
    check_eq("busy_ign_hold", 32'(bus_if.diff), 32'd11);

    // reset mid-operation aborts with no done
    start_op(4'd7, 4'd2, 1'b0);
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check_eq("abort_busy", 32'(bus_if.busy), 32'd0);
    check_eq("abort_done", 32'(bus_if.done), 32'd0);
    check_eq("abort_diff", 32'(bus_if.diff), 32'd0);
    check_eq("abort_bout", 32'(bus_if.bout), 32'd0);
    done_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (bus_if.done) done_cnt++;
    end
    check_eq("abort_no_done", 32'(done_cnt), 32'd0);
    check_eq("abort_diff_hold", 32'(bus_if.diff), 32'd0);
    start_op(4'd7, 4'd2, 1'b0);
    finish_check("7m2", 4'd5, 1'b0);
    step();

    // back-to-back: second start accepted in the done cycle
    start_op(4'd6, 4'd1, 1'b0);
    finish_check("b2b_first", 4'd5, 1'b0);
    start_op(4'd8, 4'd8, 1'b1);
    finish_check("b2b_second", 4'd15, 1'b1);
    step();
    check_eq("b2b_done_drop", 32'(bus_if.done), 32'd0);
    check_eq("b2b_hold", 32'(bus_if.diff), 32'd15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_four_bit_serial_subtractor
